// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RISC-V controller and datapath:
// FSM states, opcodes, mux selects and ALU operation codes.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JALR_ADR = 4'd10,
        S_JAL      = 4'd11,
        S_LUI      = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALUOp class handed from the FSM to the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Branch condition from the flags of rs1 - rs2; unknown funct3 is never taken.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero,
                                          input logic neg);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return neg;
            3'b101:  return !neg;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp class plus funct fields to ALUControl.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // op5 separates R-type from I-type, where funct7b5 is immediate bits
                    3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RISC-V datapath: sequences each
// instruction and drives all datapath enables and mux selects.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int STATE_W     = 4,
    parameter int RESET_STATE = 0
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    input  logic               neg,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [2:0]         ImmSrc,
    output logic               RegWrite,
    output logic [STATE_W-1:0] state
);

    localparam state_t L_RESET_STATE = state_t'(RESET_STATE[3:0]);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] w_alu_op;
    logic [2:0] w_alu_control;
    logic [2:0] w_imm_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= L_RESET_STATE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        case (opcode)
            OP_STORE:  w_imm_src = IMM_S;
            OP_BRANCH: w_imm_src = IMM_B;
            OP_JAL:    w_imm_src = IMM_J;
            OP_LUI:    w_imm_src = IMM_U;
            default:   w_imm_src = IMM_I;
        endcase
    end

    multicycle_controller_alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op5         (opcode[5]),
        .o_alu_control (w_alu_control)
    );

    always_comb begin
        w_next_state = S_FETCH;
        w_alu_op     = ALUOP_ADD;
        PCWrite      = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_REG;

        case (r_state)
            S_FETCH: begin
                IRWrite      = 1'b1;
                PCWrite      = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXECR;
                    OP_ITYPE:          w_next_state = S_EXECI;
                    OP_BRANCH:         w_next_state = S_BRANCH;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_JALR:           w_next_state = S_JALR_ADR;
                    OP_LUI:            w_next_state = S_LUI;
                    default:           w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA      = SRCA_REG;
                ALUSrcB      = SRCB_IMM;
                w_next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc       = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_MEMDATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA      = SRCA_REG;
                ALUSrcB      = SRCB_REG;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA      = SRCA_REG;
                ALUSrcB      = SRCB_IMM;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = SRCA_REG;
                ALUSrcB  = SRCB_REG;
                w_alu_op = ALUOP_SUB;
                PCWrite  = branch_taken(funct3, zero, neg);
            end
            S_JALR_ADR: begin
                ALUSrcA      = SRCA_REG;
                ALUSrcB      = SRCB_IMM;
                w_next_state = S_JAL;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while the ALU forms the link value
                PCWrite      = 1'b1;
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                w_next_state = S_ALUWB;
            end
            S_LUI: begin
                ResultSrc = RES_IMMEXT;
                RegWrite  = 1'b1;
            end
            default: w_next_state = S_FETCH;
        endcase

        ALUControl = w_alu_control;
        ImmSrc     = w_imm_src;

        if (rst) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ALUControl = 3'b000;
            ImmSrc     = 3'b000;
        end
    end

    assign state = STATE_W'(r_state);

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multi-cycle RISC-V datapath. Sequences each instruction through fetch/decode/execute/memory/writeback and drives every datapath enable and mux select. This includes the register-file write enable (RegWrite → register file WE) and ImmSrc for the immediate extender. It sits directly upstream of the register file: RegWrite is high only in writeback states.

Parameters:
STATE_W, 4, width of state register / debug state output
RESET_STATE, 0 (FETCH), state entered on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU result == 0
neg  in  1  ALU result[31]
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0=PC, 1=Result
MemWrite  out  1  data memory write
IRWrite  out  1  IR/OldPC enable
ResultSrc  out  2  00=ALUOut, 01=MemData, 10=ALUResult, 11=ImmExt
ALUSrcA  out  2  00=PC, 01=OldPC, 10=A reg
ALUSrcB  out  2  00=B reg, 01=ImmExt, 10=const 4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
RegWrite  out  1  register file write enable
state  out  STATE_W  current state (debug)

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-high (rst). rst forces state=FETCH immediately, mid-instruction included. The aborted instruction has no further effect.
- Output timing: all outputs are combinational from state (Moore), except ALUControl/ImmSrc (decoded from opcode/funct) and PCWrite in BRANCH.
- Write enables are 0 unless listed. Defaults: ALUSrcA=00, ALUSrcB=00, ResultSrc=00, ALUControl=add.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCWrite=1 → DECODE. While rst is high, outputs are forced to 0 regardless of state.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut=OldPC+imm). Next state by opcode:
  - 0000011/0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_ADR
  - 0110111 → LUI
  - any other → FETCH, no writes
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next state: MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=1, ResultSrc=00 → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from funct3/funct7b5 (add, sub, and, or, slt) → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUControl from funct3 (addi, andi, ori, slti); funct7b5 ignored → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = taken: beq zero; bne !zero; blt neg; bge !neg.
  - Other funct3 values → not taken.
  - Signed overflow is not considered.
  - → FETCH.
- JALR_ADR: ALUSrcA=10, ALUSrcB=01, add (ALUOut=rs1+imm; bit0 not cleared) → JAL.
- JAL: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10, add (ALUOut=OldPC+4) → ALUWB.
- LUI: ResultSrc=11, RegWrite=1 → FETCH.
- Latencies in cycles, FETCH inclusive:
  - lw 5; sw 4; R/I 4; branch 3; jal 4; jalr 5; lui 3; illegal 2.
- x0 protection is the register file's job; the controller asserts RegWrite even when rd=0.
- Unused state encodings → FETCH.

Decomposition:
- Shared package: state enum; opcode constants; ALUControl, ImmSrc, ResultSrc and ALUSrcA/B encodings. The datapath muxes and the ALU import the same package.
- One natural sub-module: alu_decoder (combinational; ALUOp class + funct3 + funct7b5 → ALUControl). The FSM drives its ALUOp class: add, sub, or funct.

Test Plan:
- Reset: assert rst in MEMREAD → state=FETCH within the same cycle, RegWrite=0, MemWrite=0. Release → IRWrite=1, PCWrite=1 on the next edge.
- lw (opcode 0000011) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 only in cycle 5 with ResultSrc=01.
- add vs sub (0110011, funct3=000, funct7b5=0/1) → ALUControl=000/001 in EXECR. RegWrite=1 in ALUWB, total 4 cycles.
- Branches, funct3=000/001/100/101 with (zero,neg)=(1,0) and (0,1):
  - beq: PCWrite=1 only when zero=1.
  - bne: PCWrite=1 only when zero=0.
  - blt: PCWrite=1 only when neg=1.
  - bge: PCWrite=1 only when neg=0.
  - Back to FETCH after 3 cycles in all cases.
- jalr (1100111) → JALR_ADR(ALUSrcA=10, ALUSrcB=01), JAL(PCWrite=1, ResultSrc=00), ALUWB(RegWrite=1). 5 cycles total.
- Illegal opcode 0000000 → DECODE→FETCH. No RegWrite/MemWrite/PCWrite outside FETCH.
